alu_fault_retry_ctrl: RTL
=========================

// Module: alu_fault_retry_ctrl
// PURPOSE
//  Sequences single operations into the fault-checked ALU (adder/SLL/SRA checkers) and owns error recovery.
//  For each request it drives the ALU operands and samples the result and the checker flag for the selected unit.
//  It retries on a checker error, then reports a hard fault. It permanently fences off units that exceed a fault threshold.
//  Sits between the issuing pipeline stage (req/rsp valid-ready) and the combinational ALU.
// PARAMETERS
//  MAX_RETRY     2   re-executions allowed after the first attempt (max attempts = MAX_RETRY+1)
//  RETRY_W       2   width of retry counter/report; must hold MAX_RETRY
//  CNT_W         4   width of each per-unit hard-fault counter (saturating)
//  FAULT_THRESH  2   hard-fault count at which a unit is disabled; 1..2^CNT_W-1
// PORTS
//  clock          in   1       rising-edge clock
//  reset          in   1       asynchronous, active-low reset
//  req_valid      in   1       request present
//  req_ready      out  1       controller can accept (high only in IDLE)
//  req_opcode     in   5       0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRA; others illegal
//  req_a, req_b   in   32      operands
//  req_shamt      in   5       shift amount
//  alu_opA/opB    out  32      registered operands to ALU
//  alu_opcode     out  5       registered opcode to ALU
//  alu_shamt      out  5       registered shamt to ALU
//  alu_result     in   32      ALU data_result
//  alu_ne, alu_lt in   1       ALU isNotEqual / isLessThan
//  alu_adder_err  in   1       adder checker flag
//  alu_sll_err    in   1       SLL checker flag
//  alu_sra_err    in   1       SRA checker flag
//  rsp_valid      out  1       response present
//  rsp_ready      in   1       consumer accepts response
//  rsp_result     out  32      captured result
//  rsp_ne, rsp_lt out  1       captured flags
//  rsp_fault      out  1       hard fault, disabled unit or illegal opcode
//  rsp_retries    out  RETRY_W number of retries used
//  clear_faults   in   1       synchronous clear of fault counters and disable bits
//  unit_disabled  out  3       [0] adder, [1] SLL, [2] SRA; sticky
//  fault_cnt_add/sll/sra out CNT_W  hard-fault counters
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE, req_ready=1 after release, all other outputs/regs 0, counters 0, unit_disabled 0.
//  FSM states: IDLE, EXEC, RESP.
//  IDLE: on req_valid&req_ready, latch req into alu_* regs, clear retry_cnt.
//   - Go to EXEC. Go to RESP instead if the opcode is illegal or its unit is disabled.
//   - Bypass RESP response: rsp_result=0, ne=lt=0, fault=1, retries=0, no counter change.
//  Relevant error: err_sel = adder_err (op 0/1), sll_err (op 4), sra_err (op 5), 0 (op 2/3).
//  EXEC (ALU operands stable for the whole cycle): at the clock edge, capture alu_result/ne/lt into rsp regs.
//   - err_sel=0: go to RESP, fault=0.
//   - err_sel=1 and retry_cnt<MAX_RETRY: retry_cnt++ and stay in EXEC (re-execute with same operands).
//   - err_sel=1 and retry_cnt==MAX_RETRY: go to RESP, fault=1, and increment the unit's counter (saturating at 2^CNT_W-1).
//   - Set unit_disabled bit when the counter value after update >= FAULT_THRESH.
//  RESP: rsp_valid=1; rsp_* held stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE; no same-cycle accept of a new request.
//  Latency: accept edge -> rsp_valid after 2 edges with no error; +1 cycle per retry; 1 edge for bypass.
//  Throughput: 1 op per 3 cycles at best.
//  rsp_retries = retry_cnt at RESP entry.
//  clear_faults: zeros counters and unit_disabled at next edge in any state.
//   - Overrides a same-cycle increment (clear wins).
//   - Does not disturb an operation in flight.
//  Disable takes effect for the next request; the in-flight result is still returned.
//  reset mid-operation: aborts to IDLE immediately, rsp_valid drops asynchronously, no counter update.
// TESTING
//  Reset pulse mid-EXEC -> rsp_valid=0, req_ready=1 after release, all counters and unit_disabled=0.
//  ADD 5+7, all errs 0 -> rsp_valid 2 cycles after accept, result 12, ne=1, fault=0, retries=0.
//  SLL A=1, shamt 3, sll_err=1 in first EXEC only -> result 8, retries=1, fault=0, fault_cnt_sll=0.
//  SUB 9-4, adder_err stuck 1 -> 3 EXEC cycles, fault=1, retries=2, fault_cnt_add=1; repeat -> unit_disabled=3'b001.
//   - Then ADD -> bypass response after 1 edge, fault=1, result 0.
//  Opcode 7 -> bypass response fault=1, counters unchanged.
//   - AND with sra_err=1 -> fault=0, retries=0.
//  Hold rsp_ready=0 for 4 cycles -> rsp_* stable, req_ready=0.
//   - clear_faults coincident with a hard-fault increment -> counter reads 0.

Source files
------------

// File: rtl/alu_fault_retry_ctrl.sv
// Issues one op at a time to the fault-checked ALU, retries on a checker error, reports hard
// faults and fences off units whose hard-fault count reaches FAULT_THRESH.
module alu_fault_retry_ctrl #(
  parameter int MAX_RETRY    = 2,
  parameter int RETRY_W      = 2,
  parameter int CNT_W        = 4,
  parameter int FAULT_THRESH = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [4:0]         req_opcode,
  input  logic [31:0]        req_a,
  input  logic [31:0]        req_b,
  input  logic [4:0]         req_shamt,
  output logic [31:0]        alu_opA,
  output logic [31:0]        alu_opB,
  output logic [4:0]         alu_opcode,
  output logic [4:0]         alu_shamt,
  input  logic [31:0]        alu_result,
  input  logic               alu_ne,
  input  logic               alu_lt,
  input  logic               alu_adder_err,
  input  logic               alu_sll_err,
  input  logic               alu_sra_err,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_result,
  output logic               rsp_ne,
  output logic               rsp_lt,
  output logic               rsp_fault,
  output logic [RETRY_W-1:0] rsp_retries,
  input  logic               clear_faults,
  output logic [2:0]         unit_disabled,
  output logic [CNT_W-1:0]   fault_cnt_add,
  output logic [CNT_W-1:0]   fault_cnt_sll,
  output logic [CNT_W-1:0]   fault_cnt_sra
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             opa_q, opa_d, opb_q, opb_d;
  logic [4:0]              opc_q, opc_d, shamt_q, shamt_d;
  logic [RETRY_W-1:0]      retry_q, retry_d, retries_q, retries_d;
  logic [31:0]             res_q, res_d;
  logic                    ne_q, ne_d, lt_q, lt_d, fault_q, fault_d;
  logic [2:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]              dis_q, dis_d;

  logic [2:0] req_unit, exec_unit;
  logic       req_legal, req_blocked, err_sel, retry_left;

  // One-hot unit select: [0] adder (ADD/SUB), [1] SLL, [2] SRA; AND/OR use no checked unit.
  always_comb begin
    req_unit  = {req_opcode == 5'd5, req_opcode == 5'd4,
                 (req_opcode == 5'd0) || (req_opcode == 5'd1)};
    exec_unit = {opc_q == 5'd5, opc_q == 5'd4, (opc_q == 5'd0) || (opc_q == 5'd1)};
    req_legal   = req_opcode <= 5'd5;
    req_blocked = !req_legal || |(req_unit & dis_q);
    err_sel     = |(exec_unit & {alu_sra_err, alu_sll_err, alu_adder_err});
    retry_left  = retry_q < RETRY_W'(MAX_RETRY);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = req_blocked ? S_RESP : S_EXEC;
      S_EXEC: if (!err_sel || !retry_left) state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
  end

  always_comb begin
    opa_d     = opa_q;
    opb_d     = opb_q;
    opc_d     = opc_q;
    shamt_d   = shamt_q;
    retry_d   = retry_q;
    retries_d = retries_q;
    res_d     = res_q;
    ne_d      = ne_q;
    lt_d      = lt_q;
    fault_d   = fault_q;
    cnt_d     = cnt_q;
    dis_d     = dis_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          opa_d   = req_a;
          opb_d   = req_b;
          opc_d   = req_opcode;
          shamt_d = req_shamt;
          retry_d = '0;
          if (req_blocked) begin
            res_d     = '0;
            ne_d      = 1'b0;
            lt_d      = 1'b0;
            fault_d   = 1'b1;
            retries_d = '0;
          end
        end
      end
      S_EXEC: begin
        res_d = alu_result;
        ne_d  = alu_ne;
        lt_d  = alu_lt;
        if (!err_sel) begin
          fault_d   = 1'b0;
          retries_d = retry_q;
        end else if (retry_left) begin
          retry_d = retry_q + 1'b1;
        end else begin
          fault_d   = 1'b1;
          retries_d = retry_q;
          for (int u = 0; u < 3; u++) begin
            if (exec_unit[u]) begin
              if (cnt_q[u] != {CNT_W{1'b1}}) cnt_d[u] = cnt_q[u] + 1'b1;
              if (cnt_d[u] >= CNT_W'(FAULT_THRESH)) dis_d[u] = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
    // Clearing the fault bookkeeping beats a same-cycle hard-fault increment.
    if (clear_faults) begin
      cnt_d = '0;
      dis_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opa_q     <= '0;
      opb_q     <= '0;
      opc_q     <= '0;
      shamt_q   <= '0;
      retry_q   <= '0;
      retries_q <= '0;
      res_q     <= '0;
      ne_q      <= 1'b0;
      lt_q      <= 1'b0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
      dis_q     <= '0;
    end else begin
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      opc_q     <= opc_d;
      shamt_q   <= shamt_d;
      retry_q   <= retry_d;
      retries_q <= retries_d;
      res_q     <= res_d;
      ne_q      <= ne_d;
      lt_q      <= lt_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
      dis_q     <= dis_d;
    end
  end

  assign alu_opA       = opa_q;
  assign alu_opB       = opb_q;
  assign alu_opcode    = opc_q;
  assign alu_shamt     = shamt_q;
  assign rsp_result    = res_q;
  assign rsp_ne        = ne_q;
  assign rsp_lt        = lt_q;
  assign rsp_fault     = fault_q;
  assign rsp_retries   = retries_q;
  assign unit_disabled = dis_q;
  assign fault_cnt_add = cnt_q[0];
  assign fault_cnt_sll = cnt_q[1];
  assign fault_cnt_sra = cnt_q[2];

endmodule
